// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline sequencer: stall vectors, exception codes,
// FSM states and the stall priority merge.
package pipe_ctrl_pkg;

  localparam logic [5:0] STALL_NONE = 6'b000000;
  localparam logic [5:0] STALL_IF   = 6'b000111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_INT     = 32'h0000_0001;
  localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
  localparam logic [31:0] EXC_INST    = 32'h0000_000a;
  localparam logic [31:0] EXC_OV      = 32'h0000_000c;
  localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
  localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_RECOVER = 1'b1
  } ctrl_state_t;

  // Deepest requesting stage wins; bit 5 (WB) is never stalled.
  function automatic logic [5:0] stall_encode(input logic req_if, input logic req_id,
                                              input logic req_ex, input logic req_mem);
    logic [5:0] vec;
    if (req_mem) begin
      vec = STALL_MEM;
    end else if (req_ex) begin
      vec = STALL_EX;
    end else if (req_id) begin
      vec = STALL_ID;
    end else if (req_if) begin
      vec = STALL_IF;
    end else begin
      vec = STALL_NONE;
    end
    return vec;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_watchdog.sv
// stall_watchdog: 16-bit saturating run-length counter of stalled cycles with a
// sticky flag that sets once the run reaches TIMEOUT.
module stall_watchdog
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic timeout
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT);

  logic [15:0] cnt_r;
  logic [15:0] cnt_nxt_s;
  logic        timeout_r;

  // Next run length: clear wins, otherwise count up and hold at all-ones.
  always_comb begin
    cnt_nxt_s = cnt_r;
    if (clr) begin
      cnt_nxt_s = 16'h0000;
    end else if (inc && (cnt_r != 16'hFFFF)) begin
      cnt_nxt_s = cnt_r + 16'h0001;
    end else begin
      cnt_nxt_s = cnt_r;
    end
  end

  // Counter and sticky flag; only reset can drop the flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r     <= 16'h0000;
      timeout_r <= 1'b0;
    end else begin
      cnt_r     <= cnt_nxt_s;
      timeout_r <= timeout_r | (cnt_nxt_s >= LIMIT);
    end
  end

  assign timeout = timeout_r;

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall merge, exception flush/redirect, recovery FSM and stall
// watchdog. Define PIPELINE_CTRL_PERF_EN to add the performance counters.
module pipeline_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR     = 32'h0000_0020,
  parameter int unsigned RECOVER_CYCLES = 2,
  parameter int unsigned STALL_TIMEOUT  = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_if,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        stallreq_mem,
  input  logic [31:0] excepttype_i,
  input  logic [31:0] cp0_epc_i,
  output logic [5:0]  stall,
  output logic        flush,
  output logic [31:0] new_pc,
  output logic        stall_timeout,
  output logic        ctrl_busy
`ifdef PIPELINE_CTRL_PERF_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [15:0] perf_flush_count
`endif
);

  localparam logic [2:0] REC_LOAD = 3'(RECOVER_CYCLES - 1);

  ctrl_state_t state_r;
  logic [2:0]  rec_cnt_r;
  logic        busy_r;
  logic        flush_s;
  logic [5:0]  stall_s;
  logic [31:0] new_pc_s;

  // Combinational stall/flush/redirect; an exception in RUN overrides all stalls.
  always_comb begin
    flush_s  = rst && (state_r == ST_RUN) && (excepttype_i != 32'h0000_0000);
    stall_s  = STALL_NONE;
    new_pc_s = 32'h0000_0000;
    if (flush_s) begin
      stall_s  = STALL_NONE;
      new_pc_s = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
    end else if (rst) begin
      stall_s  = stall_encode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
      new_pc_s = 32'h0000_0000;
    end else begin
      stall_s  = STALL_NONE;
      new_pc_s = 32'h0000_0000;
    end
  end

  // Recovery FSM: holds off further flushes while the pipe refills.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_RUN;
      rec_cnt_r <= 3'd0;
      busy_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_RUN: begin
          if (flush_s) begin
            state_r   <= ST_RECOVER;
            rec_cnt_r <= REC_LOAD;
            busy_r    <= 1'b1;
          end else begin
            state_r   <= ST_RUN;
            rec_cnt_r <= 3'd0;
            busy_r    <= 1'b0;
          end
        end
        ST_RECOVER: begin
          if (rec_cnt_r == 3'd0) begin
            state_r <= ST_RUN;
            busy_r  <= 1'b0;
          end else begin
            rec_cnt_r <= rec_cnt_r - 3'd1;
            busy_r    <= 1'b1;
          end
        end
        default: begin
          state_r   <= ST_RUN;
          rec_cnt_r <= 3'd0;
          busy_r    <= 1'b0;
        end
      endcase
    end
  end

  stall_watchdog #(
    .TIMEOUT(STALL_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .inc    (stall_s != STALL_NONE),
    .clr    ((stall_s == STALL_NONE) || flush_s),
    .timeout(stall_timeout)
  );

  assign stall     = stall_s;
  assign flush     = flush_s;
  assign new_pc    = new_pc_s;
  assign ctrl_busy = busy_r;

`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] perf_stall_r;
  logic [15:0] perf_flush_r;

  // Free-running wrapping event counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_stall_r <= 32'h0000_0000;
      perf_flush_r <= 16'h0000;
    end else begin
      if (stall_s != STALL_NONE) begin
        perf_stall_r <= perf_stall_r + 32'h0000_0001;
      end else begin
        perf_stall_r <= perf_stall_r;
      end
      if (flush_s) begin
        perf_flush_r <= perf_flush_r + 16'h0001;
      end else begin
        perf_flush_r <= perf_flush_r;
      end
    end
  end

  assign perf_stall_cycles = perf_stall_r;
  assign perf_flush_count  = perf_flush_r;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Randomised + directed bench for pipeline_ctrl against a cycle-level reference model.
module tb_pipeline_ctrl;

  localparam int TMO = 8;
  localparam int REC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_if = 1'b0, req_id = 1'b0, req_ex = 1'b0, req_mem = 1'b0;
  logic [31:0] exc = 32'h0, epc = 32'h0;
  logic [5:0]  stall;
  logic        flush, stall_timeout, ctrl_busy;
  logic [31:0] new_pc;
`ifdef PIPELINE_CTRL_PERF_EN
  logic [31:0] perf_stall_cycles;
  logic [15:0] perf_flush_count;
`endif

  int n_vec  = 0;
  int n_fail = 0;
  bit done   = 1'b0;

  // Reference model state
  int          m_rec_left = 0;
  int          m_run      = 0;
  bit          m_timeout  = 1'b0;
  int unsigned m_pstall   = 0;
  int unsigned m_pflush   = 0;

  pipeline_ctrl #(
    .EXC_VECTOR(32'h0000_0020), .RECOVER_CYCLES(REC), .STALL_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst(rst),
    .stallreq_if(req_if), .stallreq_id(req_id), .stallreq_ex(req_ex), .stallreq_mem(req_mem),
    .excepttype_i(exc), .cp0_epc_i(epc),
    .stall(stall), .flush(flush), .new_pc(new_pc),
    .stall_timeout(stall_timeout), .ctrl_busy(ctrl_busy)
`ifdef PIPELINE_CTRL_PERF_EN
    , .perf_stall_cycles(perf_stall_cycles), .perf_flush_count(perf_flush_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Compare process: every negedge, check DUT against the model, then advance the model.
  initial begin
    forever begin
      logic        e_flush;
      logic [5:0]  e_stall;
      logic [31:0] e_pc;
      @(negedge clk);
      if (done) break;
      if (!rst) begin
        m_rec_left = 0; m_run = 0; m_timeout = 1'b0; m_pstall = 0; m_pflush = 0;
      end
      e_flush = rst && (m_rec_left == 0) && (exc != 32'h0);
      if (!rst || e_flush)  e_stall = 6'h00;
      else if (req_mem)     e_stall = 6'b011111;
      else if (req_ex)      e_stall = 6'b001111;
      else if (req_id || req_if) e_stall = 6'b000111;
      else                  e_stall = 6'h00;
      e_pc = !e_flush ? 32'h0 : (exc == 32'he) ? epc : 32'h20;
      chk("stall", {26'h0, stall}, {26'h0, e_stall});
      chk("flush", {31'h0, flush}, {31'h0, e_flush});
      chk("new_pc", new_pc, e_pc);
      chk("ctrl_busy", {31'h0, ctrl_busy}, {31'h0, m_rec_left > 0});
      chk("stall_timeout", {31'h0, stall_timeout}, {31'h0, m_timeout});
`ifdef PIPELINE_CTRL_PERF_EN
      chk("perf_stall_cycles", perf_stall_cycles, m_pstall);
      chk("perf_flush_count", {16'h0, perf_flush_count}, {16'h0, m_pflush[15:0]});
`endif
      if (rst) begin
        if (e_flush) m_rec_left = REC;
        else if (m_rec_left > 0) m_rec_left--;
        if (e_stall != 6'h00) begin
          m_run = (m_run < 65535) ? m_run + 1 : 65535;
          m_pstall++;
        end else begin
          m_run = 0;
        end
        if (m_run >= TMO) m_timeout = 1'b1;
        if (e_flush) m_pflush++;
      end
    end
  end

  // Stimulus with literal checks at the interesting points.
  initial begin
    repeat (3) step();
    rst = 1'b1;
    #1;
    chk("reset_stall", {26'h0, stall}, 32'h0);
    chk("reset_flush", {31'h0, flush}, 32'h0);
    chk("reset_new_pc", new_pc, 32'h0);
    chk("reset_busy", {31'h0, ctrl_busy}, 32'h0);
    step();

    req_id = 1'b1; req_ex = 1'b1; #1;
    chk("id_ex_stall", {26'h0, stall}, 32'h0000_000f);
    req_ex = 1'b0; #1;
    chk("id_only_stall", {26'h0, stall}, 32'h0000_0007);
    step();

    req_id = 1'b0; req_mem = 1'b1; exc = 32'h8; #1;
    chk("syscall_flush", {31'h0, flush}, 32'h1);
    chk("syscall_stall", {26'h0, stall}, 32'h0);
    chk("syscall_pc", new_pc, 32'h20);
    step();
    req_mem = 1'b0; exc = 32'hc; #1;
    chk("rec1_busy", {31'h0, ctrl_busy}, 32'h1);
    chk("rec1_noflush", {31'h0, flush}, 32'h0);
    step(); #1;
    chk("rec2_busy", {31'h0, ctrl_busy}, 32'h1);
    chk("rec2_noflush", {31'h0, flush}, 32'h0);
    step();
    exc = 32'h0; #1;
    chk("run_busy", {31'h0, ctrl_busy}, 32'h0);
    step();

    exc = 32'he; epc = 32'h0000_1234; #1;
    chk("eret_flush", {31'h0, flush}, 32'h1);
    chk("eret_pc", new_pc, 32'h1234);
    step(); exc = 32'h0;
    step(); step(); #1;
    chk("eret_back_run", {31'h0, ctrl_busy}, 32'h0);
    step();

    req_mem = 1'b1; repeat (7) step();
    req_mem = 1'b0; step();
    req_mem = 1'b1; repeat (7) step();
    req_mem = 1'b0; #1;
    chk("wd_7_gap_7", {31'h0, stall_timeout}, 32'h0);
    step();
    req_mem = 1'b1; repeat (7) step(); #1;
    chk("wd_before_8", {31'h0, stall_timeout}, 32'h0);
    step(); req_mem = 1'b0; #1;
    chk("wd_at_8", {31'h0, stall_timeout}, 32'h1);
    step(); step(); #1;
    chk("wd_sticky", {31'h0, stall_timeout}, 32'h1);

    exc = 32'h1; step();
    exc = 32'h0; req_mem = 1'b1; #1;
    chk("mid_rec_busy", {31'h0, ctrl_busy}, 32'h1);
    rst = 1'b0; #1;
    chk("arst_stall", {26'h0, stall}, 32'h0);
    chk("arst_busy", {31'h0, ctrl_busy}, 32'h0);
    chk("arst_timeout", {31'h0, stall_timeout}, 32'h0);
    chk("arst_new_pc", new_pc, 32'h0);
    req_mem = 1'b0;
    step(); rst = 1'b1;
    step();

    repeat (3) begin
      exc = 32'h1; step();
      exc = 32'h0; step(); step();
    end
    req_if = 1'b1; repeat (5) step();
    req_if = 1'b0; #1;
`ifdef PIPELINE_CTRL_PERF_EN
    chk("perf_flush_3", {16'h0, perf_flush_count}, 32'd3);
    chk("perf_stall_5", perf_stall_cycles, 32'd5);
`endif
    step();

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        req_if  = ($urandom_range(0, 2) == 0);
        req_id  = ($urandom_range(0, 2) == 0);
        req_ex  = ($urandom_range(0, 3) == 0);
        req_mem = ($urandom_range(0, 2) == 0);
      end
      case ($urandom_range(0, 11))
        0: exc = 32'h1;
        1: exc = 32'h8;
        2: exc = 32'he;
        3: exc = $urandom;
        default: exc = 32'h0;
      endcase
      epc = $urandom;
      rst = ($urandom_range(0, 299) != 0);
      step();
      rst = 1'b1;
    end

    req_if = 1'b0; req_id = 1'b0; req_ex = 1'b0; req_mem = 1'b0; exc = 32'h0;
    step(); step();
    done = 1'b1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
